lcd_status_reader: RTL and testbench
====================================

# lcd_status_reader

Read-side companion to the team's HD44780 character-LCD writer. On request, it performs instruction-register read cycles (RS=0, RW=1) on the LCD bus and returns the busy flag (DB7) and address counter (DB6..DB0). It can also poll until the controller reports idle, so the writer can replace fixed worst-case delays with a real busy check. At top level it shares LCD_RS/LCD_RW/LCD_EN with the writer through a mux selected by `busOwned`; the top-level tristate releases LCD_DATA while `busOwned` is high.

## Interface
Parameters:
- SETUP_CYCLES, 2: cycles RS/RW are stable before EN rises (tAS ≥ 40 ns at 50 MHz); legal range ≥1.
- E_HIGH_CYCLES, 12: EN high width (≥ 230 ns); legal range ≥2.
- E_LOW_CYCLES, 12: EN low / hold / recovery after the falling edge; legal range ≥1.
- MAX_POLLS, 255: maximum reads in poll mode before timeout; legal range 1..255.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- readRequest  input  1  start a transaction; sampled only in IDLE.
- pollMode  input  1  0 = single read; 1 = repeat until BF=0 or MAX_POLLS reached. Sampled with readRequest.
- lcdDataIn  input  8  LCD_DATA pad input.
- LCD_RS  output  1  register select; always 0 in this block.
- LCD_RW  output  1  1 while `busOwned` is high, else 0.
- LCD_EN  output  1  enable strobe.
- busOwned  output  1  high from SETUP through EHOLD; selects this block in the top-level mux and tristates the data pads.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a transaction completes.
- busyFlag  output  1  DB7 from the last completed transaction.
- addressCounter  output  7  DB6..DB0 from the last completed transaction.
- timeout  output  1  set with `done` if poll mode ended with BF=1; cleared at the next accepted request.

## Operation
- FSM states: IDLE, SETUP, EHIGH, EHOLD, DONE. A single down-counter times each phase.
- IDLE: if readRequest=1, latch pollMode, clear the poll counter and `timeout`, then go to SETUP.
- SETUP: LCD_RW=1, LCD_EN=0, for SETUP_CYCLES cycles, then go to EHIGH.
- EHIGH: LCD_EN=1 for E_HIGH_CYCLES cycles. On the edge that ends the last EHIGH cycle, register lcdDataIn into a capture register and increment the poll counter. Then go to EHOLD.
- EHOLD: LCD_EN=0, LCD_RW=1, for E_LOW_CYCLES cycles. In the last cycle:
  - If the latched pollMode=1, captured DB7=1, and poll counter < MAX_POLLS, go to SETUP.
  - Otherwise go to DONE.
- DONE: for one cycle, done=1, busyFlag/addressCounter are loaded from the capture register, and timeout = latched pollMode & DB7. Then go to IDLE.
- busyFlag, addressCounter and timeout hold their values until the next DONE or reset.
- In single-read mode, BF=1 is reported as-is and timeout stays 0.
- readRequest outside IDLE is ignored. It is not queued.
- Poll counter is 8 bits and never wraps: the MAX_POLLS bound stops the loop first.

## Timing
- Reset values: LCD_RS=0, LCD_RW=0, LCD_EN=0, busOwned=0, busy=0, done=0, busyFlag=0, addressCounter=0, timeout=0, state IDLE.
- readRequest is high in cycle 0. Then SETUP occupies cycles 1..S, EHIGH occupies cycles S+1..S+H, and EHOLD occupies cycles S+H+1..S+H+L. Here S = SETUP_CYCLES, H = E_HIGH_CYCLES, L = E_LOW_CYCLES.
- Single read: done is high in cycle S+H+L+1, which is cycle 27 with default parameters. busy stays high through the done cycle.
- Poll mode: each extra read adds S+H+L cycles (26 with defaults). With N reads, done is high in cycle N·(S+H+L)+1.
- A new readRequest is accepted the cycle after done (IDLE). Minimum request-to-request spacing is S+H+L+2 cycles.
- All outputs are registered, with no combinational input-to-output paths. LCD_EN never glitches.
- Reset mid-transaction: on the next edge all outputs return to reset values, so LCD_EN drops within 1 cycle. No done pulse is produced, and captured data is discarded.
- reset and readRequest in the same cycle: reset wins, and the request is lost.

## Test plan
- Single read, lcdDataIn=8'h25 held: readRequest pulse in cycle 0 → LCD_EN high in exactly cycles 3..14; done high only in cycle 27; busyFlag=0, addressCounter=7'h25, timeout=0.
- Poll mode, lcdDataIn=8'hC0 for the first 3 reads, then 8'h40 → 4 EN pulses, done in cycle 105, busyFlag=0, addressCounter=7'h40, timeout=0.
- Poll timeout, MAX_POLLS=4, lcdDataIn=8'h80 constant → exactly 4 EN pulses, done in cycle 105, busyFlag=1, addressCounter=0, timeout=1; the next accepted request clears timeout.
- readRequest held high continuously → back-to-back transactions with done every 28 cycles; requests during busy are not queued.
- Reset asserted in cycle 8 (mid-EHIGH) → in cycle 9 LCD_EN=0, busOwned=0, busy=0, and outputs hold reset values; no done pulse appears.
- Single read with lcdDataIn=8'hFF → busyFlag=1, addressCounter=7'h7F, timeout=0; LCD_RS is 0 and LCD_RW equals busOwned throughout.

Source files
------------

// File: rtl/lcd_status_reader.sv
// lcd_status_reader: HD44780 instruction-register reader (RS=0, RW=1).
// Returns busy flag and address counter, optionally polling until idle.
module lcd_status_reader #(
    parameter int SETUP_CYCLES  = 2,
    parameter int E_HIGH_CYCLES = 12,
    parameter int E_LOW_CYCLES  = 12,
    parameter int MAX_POLLS     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       readRequest,
    input  logic       pollMode,
    input  logic [7:0] lcdDataIn,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       busOwned,
    output logic       busy,
    output logic       done,
    output logic       busyFlag,
    output logic [6:0] addressCounter,
    output logic       timeout
);

    typedef enum logic [2:0] {IDLE, SETUP, EHIGH, EHOLD, DONE} state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EHIGH_LOAD = CNT_W'(E_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ELOW_LOAD  = CNT_W'(E_LOW_CYCLES - 1);
    localparam logic [7:0]       MAX_POLLS8 = 8'(MAX_POLLS);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       poll_cnt_reg;
    logic             poll_mode_reg;
    logic [7:0]       capture_reg;
    logic             phase_end;
    logic             capture_en;
    logic             accept;

    logic rw_reg, en_reg, owned_reg, busy_reg, done_reg;
    logic rw_next, en_next, owned_next, busy_next, done_next;
    logic       busy_flag_reg;
    logic [6:0] address_counter_reg;
    logic       timeout_reg;

    assign phase_end  = (cnt_reg == '0);
    assign capture_en = (state_reg == EHIGH) && phase_end;
    assign accept     = (state_reg == IDLE) && readRequest;

    // Next-state and phase-timer logic; the counter reloads on each phase entry.
    always_comb begin
        state_next = state_reg;
        cnt_next   = phase_end ? '0 : cnt_reg - 1'b1;
        case (state_reg)
            IDLE: begin
                if (readRequest) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_next = EHIGH;
                    cnt_next   = EHIGH_LOAD;
                end
            end
            EHIGH: begin
                if (phase_end) begin
                    state_next = EHOLD;
                    cnt_next   = ELOW_LOAD;
                end
            end
            EHOLD: begin
                if (phase_end) begin
                    // poll_cnt_reg already counts the read that just finished
                    if (poll_mode_reg && capture_reg[7] && (poll_cnt_reg < MAX_POLLS8)) begin
                        state_next = SETUP;
                        cnt_next   = SETUP_LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the next state so every pad/status output is a flop.
    always_comb begin
        owned_next = (state_next == SETUP) || (state_next == EHIGH) || (state_next == EHOLD);
        rw_next    = owned_next;
        en_next    = (state_next == EHIGH);
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
    end

    // State, timer, poll bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg           <= IDLE;
            cnt_reg             <= '0;
            poll_cnt_reg        <= '0;
            poll_mode_reg       <= 1'b0;
            rw_reg              <= 1'b0;
            en_reg              <= 1'b0;
            owned_reg           <= 1'b0;
            busy_reg            <= 1'b0;
            done_reg            <= 1'b0;
            busy_flag_reg       <= 1'b0;
            address_counter_reg <= '0;
            timeout_reg         <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rw_reg    <= rw_next;
            en_reg    <= en_next;
            owned_reg <= owned_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            if (accept) begin
                poll_mode_reg <= pollMode;
                poll_cnt_reg  <= '0;
                timeout_reg   <= 1'b0;
            end else if (capture_en) begin
                poll_cnt_reg <= poll_cnt_reg + 1'b1;
            end
            if (state_next == DONE) begin
                busy_flag_reg       <= capture_reg[7];
                address_counter_reg <= capture_reg[6:0];
                timeout_reg         <= poll_mode_reg & capture_reg[7];
            end
        end
    end

    // Data-bus capture on the edge that ends EN high; reset discards it.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_capture
            always_ff @(posedge clk) begin
                if (reset) begin
                    capture_reg[gi] <= 1'b0;
                end else if (capture_en) begin
                    capture_reg[gi] <= lcdDataIn[gi];
                end
            end
        end
    endgenerate

    assign LCD_RS         = 1'b0;
    assign LCD_RW         = rw_reg;
    assign LCD_EN         = en_reg;
    assign busOwned       = owned_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign busyFlag       = busy_flag_reg;
    assign addressCounter = address_counter_reg;
    assign timeout        = timeout_reg;

endmodule

// File: tb/tb_lcd_status_reader.sv
// tb_lcd_status_reader: table-driven single reads plus hand-written poll,
// timeout, held-request and mid-transaction reset sequences, scored via a queue.
module tb_lcd_status_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       readRequest;
    logic       pollMode;
    logic [7:0] lcdDataIn;

    logic       LCD_RS, LCD_RW, LCD_EN, busOwned, busy, done, busyFlag, timeout;
    logic [6:0] addressCounter;
    logic       b_RS, b_RW, b_EN, b_owned, b_busy, b_done, b_bf, b_to;
    logic [6:0] b_ac;

    always #10 clk = ~clk;

    lcd_status_reader dut (
        .clk(clk), .reset(reset), .readRequest(readRequest), .pollMode(pollMode),
        .lcdDataIn(lcdDataIn), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
        .busOwned(busOwned), .busy(busy), .done(done), .busyFlag(busyFlag),
        .addressCounter(addressCounter), .timeout(timeout)
    );

    lcd_status_reader #(.MAX_POLLS(4)) dut_b (
        .clk(clk), .reset(reset), .readRequest(readRequest), .pollMode(pollMode),
        .lcdDataIn(lcdDataIn), .LCD_RS(b_RS), .LCD_RW(b_RW), .LCD_EN(b_EN),
        .busOwned(b_owned), .busy(b_busy), .done(b_done), .busyFlag(b_bf),
        .addressCounter(b_ac), .timeout(b_to)
    );

    typedef struct {
        logic [7:0] data;
        logic       exp_bf;
        logic [6:0] exp_ac;
    } vec_t;

    typedef struct {
        int         done_cyc;
        logic       bf;
        logic [6:0] ac;
        logic       to;
        int         pulses;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_pulses = 0;
    int en_rise_cyc = -1;
    int en_fall_cyc = -1;
    int done_seen = 0;
    logic en_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus-rule checks every cycle, EN pulse tracking, and scoreboard pops on done.
    always @(negedge clk) begin
        if (LCD_EN && !en_prev) begin
            en_pulses++;
            en_rise_cyc = cyc;
        end
        if (!LCD_EN && en_prev) en_fall_cyc = cyc;
        en_prev = LCD_EN;
        chk("rs_zero", 32'(LCD_RS), 32'd0);
        chk("rw_eq_owned", 32'(LCD_RW), 32'(busOwned));
        if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
                chk("busy_flag", 32'(busyFlag), 32'(mon_e.bf));
                chk("address_counter", 32'(addressCounter), 32'(mon_e.ac));
                chk("timeout", 32'(timeout), 32'(mon_e.to));
                chk("en_pulses", 32'(en_pulses), 32'(mon_e.pulses));
                chk("busy_in_done", 32'(busy), 32'd1);
            end
            en_pulses = 0;
        end
    end

    task automatic issue(input logic [7:0] data, input logic poll, input logic push,
                         input int len, input logic bf, input logic [6:0] ac,
                         input logic to, input int pulses, output int c0);
        exp_t e;
        @(posedge clk); #1;
        lcdDataIn   = data;
        pollMode    = poll;
        readRequest = 1'b1;
        c0 = cyc;
        if (push) begin
            e.done_cyc = cyc + len;
            e.bf = bf;
            e.ac = ac;
            e.to = to;
            e.pulses = pulses;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        readRequest = 1'b0;
    endtask

    task automatic wait_sb(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got %0d outstanding expected 0 (cycle %0d)", sb.size(), cyc);
            sb.delete();
        end
    endtask

    initial begin
        int c0, n, nb, got, got_cyc, d0;
        logic prev_loc, bprev;

        vecs[0] = '{8'hFF, 1'b1, 7'h7F};
        vecs[1] = '{8'h00, 1'b0, 7'h00};
        vecs[2] = '{8'h80, 1'b1, 7'h00};
        vecs[3] = '{8'h7F, 1'b0, 7'h7F};
        vecs[4] = '{8'h5A, 1'b0, 7'h5A};

        reset = 1'b1; readRequest = 1'b0; pollMode = 1'b0; lcdDataIn = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", 32'(LCD_EN), 0);
        chk("rst_owned", 32'(busOwned), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bf", 32'(busyFlag), 0);
        chk("rst_ac", 32'(addressCounter), 0);
        chk("rst_to", 32'(timeout), 0);
        chk("rst_rw", 32'(LCD_RW), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single read with EN window check
        issue(8'h25, 1'b0, 1'b1, 27, 1'b0, 7'h25, 1'b0, 1, c0);
        wait_sb(100);
        chk("en_rise_cycle", 32'(en_rise_cyc), 32'(c0 + 3));
        chk("en_fall_cycle", 32'(en_fall_cyc), 32'(c0 + 15));

        // table of single reads
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].data, 1'b0, 1'b1, 27, vecs[i].exp_bf, vecs[i].exp_ac, 1'b0, 1, c0);
            wait_sb(100);
            $display("single read data=%02h bf=%0b ac=%02h to=%0b", vecs[i].data, busyFlag, addressCounter, timeout);
        end

        // poll: busy for three reads, then idle
        issue(8'hC0, 1'b1, 1'b1, 105, 1'b0, 7'h40, 1'b0, 4, c0);
        n = 0; prev_loc = LCD_EN;
        for (int k = 0; k < 300 && n < 3; k++) begin
            @(negedge clk);
            if (!LCD_EN && prev_loc) n++;
            prev_loc = LCD_EN;
        end
        chk("poll_falls_seen", 32'(n), 32'd3);
        lcdDataIn = 8'h40;
        wait_sb(300);
        $display("poll read bf=%0b ac=%02h to=%0b", busyFlag, addressCounter, timeout);

        // timeout: MAX_POLLS=4 on dut_b, default 255 on dut
        issue(8'h80, 1'b1, 1'b1, 255 * 26 + 1, 1'b1, 7'h00, 1'b1, 255, c0);
        nb = 0; got = 0; got_cyc = -1; bprev = 1'b0;
        for (int k = 0; k < 300 && got == 0; k++) begin
            @(negedge clk);
            if (b_EN && !bprev) nb++;
            bprev = b_EN;
            if (b_done) begin
                got = 1;
                got_cyc = cyc;
            end
        end
        chk("b_done_seen", 32'(got), 32'd1);
        chk("b_done_cycle", 32'(got_cyc), 32'(c0 + 105));
        chk("b_en_pulses", 32'(nb), 32'd4);
        chk("b_busy_flag", 32'(b_bf), 32'd1);
        chk("b_address_counter", 32'(b_ac), 32'd0);
        chk("b_timeout", 32'(b_to), 32'd1);
        $display("poll timeout max4 bf=%0b ac=%02h to=%0b at +%0d", b_bf, b_ac, b_to, got_cyc - c0);
        wait_sb(7000);
        issue(8'h00, 1'b0, 1'b1, 27, 1'b0, 7'h00, 1'b0, 1, c0);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        chk("b_timeout_cleared", 32'(b_to), 32'd0);
        wait_sb(100);

        // readRequest held high: done every 28 cycles, no queuing
        d0 = done_seen;
        @(posedge clk); #1;
        lcdDataIn = 8'h33; pollMode = 1'b0; readRequest = 1'b1; c0 = cyc;
        for (int t = 0; t < 3; t++) sb.push_back('{c0 + 27 + 28 * t, 1'b0, 7'h33, 1'b0, 1});
        while (cyc < c0 + 70) begin
            @(posedge clk); #1;
        end
        readRequest = 1'b0;
        wait_sb(200);
        repeat (40) @(negedge clk);
        chk("held_done_count", 32'(done_seen - d0), 32'd3);
        chk("held_idle_after", 32'(busy), 32'd0);
        $display("held request dones=%0d", done_seen - d0);

        // reset mid-EHIGH
        issue(8'h25, 1'b0, 1'b0, 0, 1'b0, 7'h00, 1'b0, 0, c0);
        while (cyc < c0 + 8) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_en", 32'(LCD_EN), 0);
        chk("mid_rst_owned", 32'(busOwned), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_ac", 32'(addressCounter), 0);
        chk("mid_rst_rw", 32'(LCD_RW), 0);
        d0 = done_seen;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_seen - d0), 32'd0);
        $display("reset mid-transaction en=%0b busy=%0b ac=%02h", LCD_EN, busy, addressCounter);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
